// File: rtl/fifo_pkg.sv
// Shared constants and state encoding for the threshold FIFO family.
package fifo_pkg;

    // Default widths, matching the FSM threshold outputs.
    localparam int FIFO_DATA_SIZE   = 6;
    localparam int FIFO_ADDR_SIZE   = 3;
    localparam int FIFO_UMBRAL_SIZE = 3;

    // Protocol state: ERROR is sticky until reset.
    typedef enum logic {
        NORMAL = 1'b0,
        ERROR  = 1'b1
    } state_t;

endpackage

// File: rtl/fifo_mem.sv
// Register-file storage for the FIFO: synchronous write, synchronous read, no reset.
module fifo_mem #(
    parameter int DATA_SIZE = 6,
    parameter int ADDR_SIZE = 3
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDR_SIZE-1:0] wr_addr,
    input  logic [DATA_SIZE-1:0] wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_SIZE-1:0] rd_addr,
    output logic [DATA_SIZE-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_SIZE;

    logic [DATA_SIZE-1:0] mem [DEPTH];

    // Write port: store the pushed word at the write pointer.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port: capture the oldest word; a same-edge write to this slot is not seen.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fifo_umbral.sv
// Synchronous FIFO with live almost-full/almost-empty thresholds and a sticky
// protocol-error state (overflow without pop, or pop while empty).
module fifo_umbral
    import fifo_pkg::*;
#(
    parameter int DATA_SIZE   = FIFO_DATA_SIZE,
    parameter int ADDR_SIZE   = FIFO_ADDR_SIZE,
    parameter int UMBRAL_SIZE = FIFO_UMBRAL_SIZE
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_SIZE-1:0]   data_in,
    input  logic                   push,
    input  logic                   pop,
    input  logic [UMBRAL_SIZE-1:0] full_umbral_in,
    input  logic [UMBRAL_SIZE-1:0] empty_umbral_in,
    output logic [DATA_SIZE-1:0]   data_out,
    output logic                   valid_out,
    output logic                   full_sig,
    output logic                   empty_sig,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic                   err_sig
);

    localparam int                CNT_W = ADDR_SIZE + 1;
    localparam logic [CNT_W-1:0]  DEPTH = CNT_W'(2 ** ADDR_SIZE);

    state_t                 state;
    state_t                 state_nxt;
    logic [ADDR_SIZE-1:0]   wr_ptr;
    logic [ADDR_SIZE-1:0]   rd_ptr;
    logic [CNT_W-1:0]       count;
    logic [CNT_W-1:0]       count_nxt;
    logic [CNT_W-1:0]       full_th;
    logic [CNT_W-1:0]       empty_th;
    logic                   is_full;
    logic                   is_empty;
    logic                   err_evt;
    logic                   do_push;
    logic                   do_pop;
    logic                   rd_seen;
    logic [DATA_SIZE-1:0]   rd_data;

    fifo_mem #(
        .DATA_SIZE (DATA_SIZE),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_mem (
        .clk     (clk),
        .wr_en   (do_push),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_en   (do_pop),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    // Qualify requests against the current occupancy and derive the next count.
    always_comb begin
        is_full   = (count == DEPTH);
        is_empty  = (count == '0);
        err_evt   = (state == NORMAL) && ((push && !pop && is_full) || (pop && is_empty));
        do_pop    = (state == NORMAL) && pop && !is_empty;
        do_push   = (state == NORMAL) && push && !err_evt && (!is_full || pop);
        full_th   = CNT_W'(full_umbral_in);
        empty_th  = CNT_W'(empty_umbral_in);
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_nxt = count - CNT_W'(1);
        end
    end

    // State register: only reset leaves ERROR.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= NORMAL;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: any protocol violation while NORMAL enters ERROR.
    always_comb begin
        state_nxt = state;
        if (err_evt) begin
            state_nxt = ERROR;
        end
    end

    // Output logic: error flag from state, data forced to zero until the first pop after reset.
    always_comb begin
        err_sig  = (state == ERROR);
        data_out = rd_seen ? rd_data : '0;
    end

    // Pointers, occupancy, read-valid and registered flags from the next count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            valid_out    <= 1'b0;
            rd_seen      <= 1'b0;
            full_sig     <= 1'b0;
            empty_sig    <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + ADDR_SIZE'(1);
            end
            if (do_pop) begin
                rd_ptr  <= rd_ptr + ADDR_SIZE'(1);
                rd_seen <= 1'b1;
            end
            count        <= count_nxt;
            valid_out    <= do_pop;
            full_sig     <= (count_nxt == DEPTH);
            empty_sig    <= (count_nxt == '0);
            almost_full  <= (count_nxt >= full_th);
            almost_empty <= (count_nxt <= empty_th);
        end
    end

endmodule

// File: tb/tb_fifo_umbral.sv
// Bench for fifo_umbral: queue-based reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fifo_umbral;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] data_in = '0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic [2:0] full_umbral_in = 3'd6;
    logic [2:0] empty_umbral_in = 3'd1;
    logic [5:0] data_out;
    logic       valid_out;
    logic       full_sig;
    logic       empty_sig;
    logic       almost_full;
    logic       almost_empty;
    logic       err_sig;

    fifo_umbral dut (
        .clk             (clk),
        .reset           (reset),
        .data_in         (data_in),
        .push            (push),
        .pop             (pop),
        .full_umbral_in  (full_umbral_in),
        .empty_umbral_in (empty_umbral_in),
        .data_out        (data_out),
        .valid_out       (valid_out),
        .full_sig        (full_sig),
        .empty_sig       (empty_sig),
        .almost_full     (almost_full),
        .almost_empty    (almost_empty),
        .err_sig         (err_sig)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    // Reference model state
    logic [5:0] mq[$];
    bit         m_err   = 1'b0;
    logic [5:0] m_dout  = '0;
    bit         m_valid = 1'b0;
    bit         m_full  = 1'b0;
    bit         m_empty = 1'b1;
    bit         m_af    = 1'b0;
    bit         m_ae    = 1'b1;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO as a queue, errors sticky until reset.
    always @(posedge clk) begin
        int n;
        if (!reset) begin
            mq.delete();
            m_err = 1'b0; m_dout = '0; m_valid = 1'b0;
            m_full = 1'b0; m_empty = 1'b1; m_af = 1'b0; m_ae = 1'b1;
        end else begin
            m_valid = 1'b0;
            if (!m_err) begin
                if (pop && mq.size() == 0) begin
                    m_err = 1'b1;
                end else if (push && !pop && mq.size() == 8) begin
                    m_err = 1'b1;
                end else begin
                    if (pop) begin
                        m_dout  = mq.pop_front();
                        m_valid = 1'b1;
                    end
                    if (push) mq.push_back(data_in);
                end
            end
            n = mq.size();
            m_full  = (n == 8);
            m_empty = (n == 0);
            m_af    = (n >= int'(full_umbral_in));
            m_ae    = (n <= int'(empty_umbral_in));
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("data_out",     int'(data_out),     int'(m_dout));
            check("valid_out",    int'(valid_out),    int'(m_valid));
            check("full_sig",     int'(full_sig),     int'(m_full));
            check("empty_sig",    int'(empty_sig),    int'(m_empty));
            check("almost_full",  int'(almost_full),  int'(m_af));
            check("almost_empty", int'(almost_empty), int'(m_ae));
            check("err_sig",      int'(err_sig),      int'(m_err));
        end
    end

    task automatic step(input logic rst_n, input logic psh, input logic pp, input logic [5:0] d);
        reset   = rst_n;
        push    = psh;
        pop     = pp;
        data_in = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // Reset and idle
        step(1'b0, 1'b0, 1'b0, 6'd0);
        chk_en = 1'b1;
        step(1'b0, 1'b0, 1'b0, 6'd0);
        step(1'b1, 1'b0, 1'b0, 6'd0);
        check("lit_reset_empty",  int'(empty_sig),    1);
        check("lit_reset_aempty", int'(almost_empty), 1);
        check("lit_reset_full",   int'(full_sig),     0);
        check("lit_reset_err",    int'(err_sig),      0);
        check("lit_reset_valid",  int'(valid_out),    0);

        // Fill, drain, twice for pointer wrap
        full_umbral_in  = 3'd6;
        empty_umbral_in = 3'd1;
        for (int r = 0; r < 2; r++) begin
            for (int i = 1; i <= 8; i++) begin
                step(1'b1, 1'b1, 1'b0, 6'(i));
                if (i == 5) check("lit_af_cnt5", int'(almost_full), 0);
                if (i == 6) check("lit_af_cnt6", int'(almost_full), 1);
            end
            check("lit_full_cnt8", int'(full_sig), 1);
            for (int i = 1; i <= 8; i++) begin
                step(1'b1, 1'b0, 1'b1, 6'd0);
                check("lit_pop_data",  int'(data_out),  i);
                check("lit_pop_valid", int'(valid_out), 1);
                if (i == 7) check("lit_ae_cnt1", int'(almost_empty), 1);
            end
            check("lit_drained_empty", int'(empty_sig), 1);
            step(1'b1, 1'b0, 1'b0, 6'd0);
        end

        // Simultaneous push/pop at full
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 6'(8'h10 + i));
        step(1'b1, 1'b1, 1'b1, 6'h2A);
        check("lit_pp_full_data", int'(data_out), 8'h10);
        check("lit_pp_full_full", int'(full_sig), 1);
        check("lit_pp_full_err",  int'(err_sig),  0);

        // Overflow
        step(1'b1, 1'b1, 1'b0, 6'h3F);
        check("lit_ovf_err", int'(err_sig), 1);
        step(1'b1, 1'b0, 1'b1, 6'd0);
        check("lit_ovf_pop_ignored", int'(valid_out), 0);
        check("lit_ovf_err_sticky",  int'(err_sig),   1);
        step(1'b0, 1'b0, 1'b0, 6'd0);
        check("lit_ovf_err_cleared", int'(err_sig), 0);

        // Underflow: pop alone, then push+pop
        step(1'b1, 1'b0, 1'b1, 6'd0);
        check("lit_udf_err",   int'(err_sig),   1);
        check("lit_udf_empty", int'(empty_sig), 1);
        step(1'b0, 1'b0, 1'b0, 6'd0);
        step(1'b1, 1'b1, 1'b1, 6'h33);
        check("lit_udf_pp_err",   int'(err_sig),   1);
        check("lit_udf_pp_empty", int'(empty_sig), 1);
        step(1'b0, 1'b0, 1'b0, 6'd0);

        // Threshold change with no traffic
        full_umbral_in = 3'd5;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 6'(i));
        check("lit_th_before", int'(almost_full), 0);
        full_umbral_in = 3'd3;
        step(1'b1, 1'b0, 1'b0, 6'd0);
        check("lit_th_after", int'(almost_full), 1);

        // Zero almost-full threshold on an empty FIFO
        step(1'b0, 1'b0, 1'b0, 6'd0);
        full_umbral_in = 3'd0;
        step(1'b1, 1'b0, 1'b0, 6'd0);
        check("lit_th_zero_af", int'(almost_full), 1);
        check("lit_th_zero_err", int'(err_sig), 0);

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            logic p, q, rn;
            if ($urandom_range(0, 15) == 0) full_umbral_in  = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) empty_umbral_in = 3'($urandom_range(0, 7));
            q  = ($urandom_range(0, 3) != 0) && (mq.size() > 0 || $urandom_range(0, 25) == 0);
            p  = ($urandom_range(0, 1) == 1) && (mq.size() < 8 || q || $urandom_range(0, 25) == 0);
            rn = !((m_err && $urandom_range(0, 5) == 0) || $urandom_range(0, 150) == 0);
            step(rn, p, q, 6'($urandom));
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
